vga_state_fetch: RTL and testbench

Scheduler that owns the game-state path into the VGA pixel generator. Once per frame, on the rising edge of vertical blanking, it takes the single-port data memory away from the CPU for three cycles. In that window it reads the board word, the column word and the player word. It then commits all three to its outputs in one cycle, so the pixel generator never shows a half-updated board. Outside that window the CPU owns the memory port unchanged.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_state_fetch_if.sv | 29 ++
 rtl/vga_edge_detect.sv | 21 ++
 rtl/vga_state_fetch.sv | 104 ++++++++++
 tb/tb_vga_state_fetch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA game-state fetch path.
package vga_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t BOARD_ADDR  = 16'h0FF0;
  localparam addr_t COL_ADDR    = 16'h0FF1;
  localparam addr_t PLAYER_ADDR = 16'h0FF2;

  typedef enum logic [2:0] {
    IDLE,
    RD_BOARD,
    RD_COL,
    RD_PLAYER,
    CAP_PLAYER,
    COMMIT
  } fetch_state_t;

endpackage

// File: rtl/vga_state_fetch_if.sv
// CPU request port and single-port memory bus shared with the state fetcher.
interface vga_state_fetch_if;
  import vga_pkg::*;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_wdata;
  logic  cpu_stall;
  data_t cpu_rdata;

  addr_t mem_addr;
  logic  mem_we;
  data_t mem_wdata;
  data_t mem_rdata;

  // CPU plus memory environment.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_stall, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  // The scheduler sitting between CPU and memory.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_stall, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vga_edge_detect.sv
// Rising-edge detector; the delayed copy resets low so a level already high
// when reset releases still produces an edge.
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  // NOTE: registered state always uses non-blocking assignment so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/vga_state_fetch.sv
// Once-per-frame snapshot of board/column/player words, committed atomically
// so the pixel generator never sees a half-updated board.
module vga_state_fetch
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vblank,
  vga_state_fetch_if.slave   bus,
  output data_t              game_board,
  output data_t              column_no,
  output data_t              player,
  output logic               frame_updated
);

  fetch_state_t state;
  logic         start;
  data_t        shadow_board;
  data_t        shadow_col;
  data_t        shadow_player;

  vga_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (vblank),
    .rise (start)
  );

  // Each capture lands one state after its address, matching the memory's
  // one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shadow_board  <= '0;
      shadow_col    <= '0;
      shadow_player <= '0;
      game_board    <= '0;
      column_no     <= '0;
      player        <= '0;
      frame_updated <= 1'b0;
    end else begin
      frame_updated <= 1'b0;
      case (state)
        IDLE:       if (start) state <= RD_BOARD;
        RD_BOARD:   state <= RD_COL;
        RD_COL: begin
          shadow_board <= bus.mem_rdata;
          state        <= RD_PLAYER;
        end
        RD_PLAYER: begin
          shadow_col <= bus.mem_rdata;
          state      <= CAP_PLAYER;
        end
        CAP_PLAYER: begin
          shadow_player <= bus.mem_rdata;
          state         <= COMMIT;
        end
        COMMIT: begin
          game_board    <= shadow_board;
          column_no     <= shadow_col;
          player        <= shadow_player;
          frame_updated <= 1'b1;
          state         <= IDLE;
        end
        default:    state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_we    = bus.cpu_req & bus.cpu_we;
    bus.mem_wdata = bus.cpu_wdata;
    bus.cpu_stall = 1'b0;
    case (state)
      RD_BOARD: begin
        bus.mem_addr  = BOARD_ADDR;
        bus.mem_we    = 1'b0;
        bus.cpu_stall = bus.cpu_req;
      end
      RD_COL: begin
        bus.mem_addr  = COL_ADDR;
        bus.mem_we    = 1'b0;
        bus.cpu_stall = bus.cpu_req;
      end
      RD_PLAYER: begin
        bus.mem_addr  = PLAYER_ADDR;
        bus.mem_we    = 1'b0;
        bus.cpu_stall = bus.cpu_req;
      end
      default: ;
    endcase
    // Hold the CPU off and keep memory safe while reset is applied.
    if (rst) begin
      bus.cpu_stall = 1'b1;
      bus.mem_we    = 1'b0;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_vga_state_fetch.sv
// Scoreboard bench: each vblank edge pushes the expected snapshot and commit
// cycle; the frame_updated monitor pops and compares.
module tb_vga_state_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic [15:0] game_board, column_no, player;
  logic        frame_updated;

  vga_state_fetch_if bus ();

  vga_state_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .vblank        (vblank),
    .bus           (bus),
    .game_board    (game_board),
    .column_no     (column_no),
    .player        (player),
    .frame_updated (frame_updated)
  );

  always #10 clk = ~clk;

  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] board;
    logic [15:0] col;
    logic [15:0] plyr;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] p, input int at);
    exp_t e;
    e.board = b; e.col = c; e.plyr = p; e.at = at;
    sb.push_back(e);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    next_cycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  // Commit monitor: every frame_updated pulse must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_updated === 1'b1) begin
        n_pulses++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("commit_cycle", cyc, e.at);
          check("game_board",   game_board, e.board);
          check("column_no",    column_no,  e.col);
          check("player",       player,     e.plyr);
        end
      end
    end
  end

  initial begin
    int n;
    int pulses_before;
    logic [15:0] exp_addr;

    rst = 1'b1; vblank = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0FF0; bus.cpu_wdata = 16'hFFFF;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_stall", bus.cpu_stall, 1);
    check("rst_mem_we", bus.mem_we, 0);
    next_cycle();
    rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    check("rst_board", game_board, 0);
    check("rst_col", column_no, 0);
    check("rst_player", player, 0);
    check("rst_fu", frame_updated, 0);
    bus.cpu_we = 1'b1;
    @(negedge clk);
    check("noreq_no_we", bus.mem_we, 0);
    next_cycle();
    bus.cpu_we = 1'b0;

    cpu_write(16'h0FF0, 16'hA5A5);
    cpu_write(16'h0FF1, 16'h0003);
    cpu_write(16'h0FF2, 16'h0001);
    cpu_write(16'h0010, 16'hBEEF);
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
    next_cycle();
    @(negedge clk);
    check("cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    next_cycle();

    // Basic fetch with a CPU read held across the window.
    vblank = 1'b1; n = cyc;
    push_exp(16'hA5A5, 16'h0003, 16'h0001, n + 6);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_addr = (k == 1) ? 16'h0FF0 : (k == 2) ? 16'h0FF1 :
                 (k == 3) ? 16'h0FF2 : 16'h0010;
      check($sformatf("stall_k%0d", k), bus.cpu_stall, (k >= 1 && k <= 3));
      check($sformatf("addr_k%0d", k), bus.mem_addr, exp_addr);
      if (k < 6) check($sformatf("hold_board_k%0d", k), game_board, 0);
      if (k == 7) check("fu_one_cycle", frame_updated, 0);
      next_cycle();
    end
    vblank = 1'b0; bus.cpu_req = 1'b0;
    repeat (3) next_cycle();

    // CPU write to the board word issued during RD_COL.
    vblank = 1'b1; n = cyc;
    push_exp(16'hA5A5, 16'h0003, 16'h0001, n + 6);
    next_cycle();
    next_cycle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0FF0; bus.cpu_wdata = 16'h1111;
    @(negedge clk);
    check("wr_rdcol_stall", bus.cpu_stall, 1);
    check("wr_rdcol_no_we", bus.mem_we, 0);
    next_cycle();
    @(negedge clk);
    check("wr_rdply_stall", bus.cpu_stall, 1);
    next_cycle();
    @(negedge clk);
    check("wr_cap_stall", bus.cpu_stall, 0);
    check("wr_cap_we", bus.mem_we, 1);
    next_cycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    repeat (3) next_cycle();
    vblank = 1'b0;
    repeat (3) next_cycle();
    vblank = 1'b1; n = cyc;
    push_exp(16'h1111, 16'h0003, 16'h0001, n + 6);
    repeat (8) next_cycle();
    vblank = 1'b0;
    repeat (3) next_cycle();

    // CPU write to the player word in the start cycle.
    vblank = 1'b1; n = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0FF2; bus.cpu_wdata = 16'h0002;
    push_exp(16'h1111, 16'h0003, 16'h0002, n + 6);
    @(negedge clk);
    check("start_wr_stall", bus.cpu_stall, 0);
    check("start_wr_we", bus.mem_we, 1);
    next_cycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    repeat (8) next_cycle();
    vblank = 1'b0;
    repeat (3) next_cycle();

    // Reset pulse in RD_PLAYER; vblank stays high and retriggers a full fetch.
    vblank = 1'b1; n = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    repeat (3) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", bus.cpu_stall, 1);
    next_cycle();
    rst = 1'b0;
    push_exp(16'h1111, 16'h0003, 16'h0002, n + 10);
    @(negedge clk);
    check("midrst_board", game_board, 0);
    check("midrst_col", column_no, 0);
    check("midrst_player", player, 0);
    check("midrst_fu", frame_updated, 0);
    check("midrst_idle", bus.cpu_stall, 0);
    next_cycle();
    @(negedge clk);
    check("refetch_stall", bus.cpu_stall, 1);
    repeat (7) next_cycle();
    bus.cpu_req = 1'b0; vblank = 1'b0;
    repeat (3) next_cycle();

    // Long vblank must yield exactly one fetch per rising edge.
    for (int f = 0; f < 2; f++) begin
      pulses_before = n_pulses;
      vblank = 1'b1; n = cyc;
      push_exp(16'h1111, 16'h0003, 16'h0002, n + 6);
      repeat (200) next_cycle();
      vblank = 1'b0;
      repeat (3) next_cycle();
      check($sformatf("one_pulse_f%0d", f), n_pulses - pulses_before, 1);
    end

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
